// File: rtl/data_ram_ctrl_pkg.sv
// data_ram_ctrl_pkg
//   Shared definitions for the data RAM controller: FSM state encodings,
//   reset/write/chip-enable polarities, the zero word, and the address
//   range helper used to flag accesses beyond the implemented word array.
package data_ram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        ChipEnable   = 1'b1;
    localparam logic        ChipDisable  = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    // True when any byte-address bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int          depth_log2);
        return (addr >> (depth_log2 + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/data_ram_ctrl_ram_byte_array.sv
// ram_byte_array
//   Word array of 2^ADDR_W 32-bit words with four independently writable
//   byte lanes. Writes occur on the rising clock edge; the read port is a
//   combinational view of the addressed word. Contents are never reset.
//
//   Ports:
//     clk   - clock
//     we    - write strobe for this edge
//     sel   - byte-lane enables, bit n covers wdata[8n+7:8n]
//     addr  - word index
//     wdata - write data
//     rdata - current contents of the addressed word
module ram_byte_array #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1 << ADDR_W) - 1];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (sel[lane]) begin
                    mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl
//   Cache-facing data RAM controller. A request presented while idle is
//   accepted and completes LATENCY cycles later with a one-cycle ack.
//   Writes commit byte lanes selected by ram_sel_i; reads return the full
//   word. Addresses beyond the array raise ram_err_o with the ack, drop
//   writes and return zero on reads.
//
//   Handshake: ram_ce_i is sampled only in IDLE; the transaction is latched
//   at that edge and runs to completion regardless of ram_ce_i afterwards.
//   ram_ack_o is high for exactly one cycle per accepted request, and
//   stallreq holds the requester off until it sees that ack.
//
//   Ports:
//     clk, rst          - clock, asynchronous active-low reset
//     ram_ce_i          - request valid
//     ram_we_i          - 1 = write, 0 = read
//     ram_addr_i        - byte address (low two bits ignored)
//     ram_sel_i         - byte-lane enables
//     ram_data_i        - write data
//     ram_data_o        - read data, held until the next read completes
//     ram_ack_o         - completion pulse
//     ram_err_o         - out-of-range flag, valid with ack
//     stallreq          - ram_ce_i AND NOT ram_ack_o
//     dbg_state         - current FSM state encoding
module data_ram_ctrl
    import data_ram_ctrl_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_ce_i,
    input  logic        ram_we_i,
    input  logic [31:0] ram_addr_i,
    input  logic [3:0]  ram_sel_i,
    input  logic [31:0] ram_data_i,
    output logic [31:0] ram_data_o,
    output logic        ram_ack_o,
    output logic        ram_err_o,
    output logic        stallreq,
    output logic [1:0]  dbg_state
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [3:0]  lat_sel;
    logic [31:0] lat_data;

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_sel;
    logic [31:0] cur_data;
    logic        cur_oob;

    logic        enter_ack;
    logic        mem_we;
    logic        rd_load;
    logic [31:0] mem_rdata;
    logic        accept;

    // With LATENCY=1 the commit edge is the accept edge itself, so the
    // transaction must come straight from the inputs while idle.
    assign cur_we   = (state == ST_IDLE) ? ram_we_i   : lat_we;
    assign cur_addr = (state == ST_IDLE) ? ram_addr_i : lat_addr;
    assign cur_sel  = (state == ST_IDLE) ? ram_sel_i  : lat_sel;
    assign cur_data = (state == ST_IDLE) ? ram_data_i : lat_data;
    assign cur_oob  = addr_out_of_range(cur_addr, DEPTH_LOG2);

    // Byte offset bits are don't-care: accesses are word aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cur_addr[1:0];

    assign accept   = (state == ST_IDLE) && (ram_ce_i == ChipEnable);
    assign stallreq = (ram_ce_i != ChipDisable) && !ram_ack_o;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (ram_ce_i == ChipEnable) begin
                    state_next = (LATENCY == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / strobe logic
    always_comb begin
        enter_ack = (state_next == ST_ACK) && (state != ST_ACK);
        mem_we    = enter_ack && (cur_we == WriteEnable) && !cur_oob;
        rd_load   = enter_ack && (cur_we == WriteDisable);
        dbg_state = state;
    end

    // Transaction latch, wait counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            lat_we     <= WriteDisable;
            lat_addr   <= ZeroWord;
            lat_sel    <= 4'b0000;
            lat_data   <= ZeroWord;
            cnt        <= 4'd0;
            ram_data_o <= ZeroWord;
            ram_ack_o  <= 1'b0;
            ram_err_o  <= 1'b0;
        end else begin
            if (accept) begin
                lat_we   <= ram_we_i;
                lat_addr <= ram_addr_i;
                lat_sel  <= ram_sel_i;
                lat_data <= ram_data_i;
                cnt      <= (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
            end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            ram_ack_o <= enter_ack;
            ram_err_o <= enter_ack && cur_oob;

            if (rd_load) begin
                ram_data_o <= cur_oob ? ZeroWord : mem_rdata;
            end
        end
    end

    ram_byte_array #(
        .ADDR_W(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .sel   (cur_sel),
        .addr  (cur_addr[DEPTH_LOG2+1:2]),
        .wdata (cur_data),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl
//   Directed bench for data_ram_ctrl with DEPTH_LOG2=10, LATENCY=2.
//   A table of single transactions is applied in a loop, followed by
//   hand-written sequences for back-to-back requests, request withdrawal
//   after accept, and reset in the middle of a write.
module tb_data_ram_ctrl;

    localparam int DEPTH_LOG2 = 10;
    localparam int LATENCY    = 2;
    localparam int MAX_WAIT   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_ce_i = 1'b0;
    logic        ram_we_i = 1'b0;
    logic [31:0] ram_addr_i = '0;
    logic [3:0]  ram_sel_i = '0;
    logic [31:0] ram_data_i = '0;
    logic [31:0] ram_data_o;
    logic        ram_ack_o;
    logic        ram_err_o;
    logic        stallreq;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    data_ram_ctrl #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ram_ce_i  (ram_ce_i),
        .ram_we_i  (ram_we_i),
        .ram_addr_i(ram_addr_i),
        .ram_sel_i (ram_sel_i),
        .ram_data_i(ram_data_i),
        .ram_data_o(ram_data_o),
        .ram_ack_o (ram_ack_o),
        .ram_err_o (ram_err_o),
        .stallreq  (stallreq),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge with the DUT idle. Presents one
    // request, waits (bounded) for the ack, then releases ce and checks the
    // ack is a single-cycle pulse. cycles=0 means no ack was seen.
    task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input logic drop_ce, output int cycles,
                           output logic [31:0] data, output logic err);
        ram_ce_i   = 1'b1;
        ram_we_i   = we;
        ram_addr_i = addr;
        ram_sel_i  = sel;
        ram_data_i = wdata;
        cycles = 0;
        data   = '0;
        err    = 1'b0;
        for (int i = 1; i <= MAX_WAIT; i++) begin
            @(negedge clk);
            if (ram_ack_o) begin
                if (!drop_ce) check({name, ".stall_at_ack"}, {31'd0, stallreq}, 32'd0);
                cycles = i;
                data   = ram_data_o;
                err    = ram_err_o;
                break;
            end
            if (!drop_ce) check({name, ".stall_wait"}, {31'd0, stallreq}, 32'd1);
            if (drop_ce) ram_ce_i = 1'b0;
        end
        ram_ce_i = 1'b0;
        @(negedge clk);
        check({name, ".ack_pulse"}, {30'd0, ram_ack_o, ram_err_o}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    initial begin
        int          cyc;
        logic [31:0] d;
        logic        e;
        int          n_acks;

        // writes expect ram_data_o to still hold the last read result
        vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'b0101, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 32'hDE22_BE44, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_1000, 4'b1111, 32'h1234_5678, 32'hDE22_BE44, 1'b1};
        vecs[6]  = '{1'b0, 32'h0000_1000, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 4'b1111, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0013, 4'b1111, 32'h0000_0000, 32'hDE22_BE44, 1'b0};
        vecs[9]  = '{1'b1, 32'h0000_0020, 4'b1111, 32'hA5A5_A5A5, 32'hDE22_BE44, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0020, 4'b0000, 32'hFFFF_FFFF, 32'hDE22_BE44, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0020, 4'b1111, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0FFC, 4'b1111, 32'h0102_0304, 32'hA5A5_A5A5, 1'b0};
        vecs[13] = '{1'b1, 32'h0000_0FFE, 4'b1000, 32'hAABB_CCDD, 32'hA5A5_A5A5, 1'b0};
        vecs[14] = '{1'b0, 32'h0000_0FFC, 4'b1111, 32'h0000_0000, 32'hAA02_0304, 1'b0};
        vecs[15] = '{1'b0, 32'h8000_0010, 4'b1111, 32'h0000_0000, 32'h0000_0000, 1'b1};

        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.data",  ram_data_o, 32'd0);
        check("rst.ack",   {31'd0, ram_ack_o}, 32'd0);
        check("rst.err",   {31'd0, ram_err_o}, 32'd0);
        check("rst.stall", {31'd0, stallreq}, 32'd0);
        check("rst.state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // ---------------- table ----------------
        for (int v = 0; v < NVEC; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            run_txn(nm, vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].wdata, 1'b0, cyc, d, e);
            check({nm, ".latency"}, cyc, LATENCY);
            check({nm, ".data"}, d, vecs[v].exp_data);
            check({nm, ".err"}, {31'd0, e}, {31'd0, vecs[v].exp_err});
        end

        // ---------------- ce held high: ack every LATENCY+1 cycles ----------------
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd8);
        n_acks = 0;
        ram_ce_i   = 1'b1;
        ram_we_i   = 1'b0;
        ram_addr_i = 32'h0000_0010;
        ram_sel_i  = 4'b1111;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ram_ack_o) begin
                n_acks++;
                if (exp_q.size() > 0) check("b2b.ack_pos", i, exp_q.pop_front());
                else check("b2b.extra_ack", i, 32'd0);
                check("b2b.data", ram_data_o, 32'hDE22_BE44);
            end
        end
        ram_ce_i = 1'b0;
        check("b2b.ack_count", n_acks, 32'd3);
        @(negedge clk);
        check("b2b.idle_ack", {31'd0, ram_ack_o}, 32'd0);

        // ---------------- ce dropped after accept ----------------
        run_txn("drop", 1'b1, 32'h0000_0024, 4'b1111, 32'h0BAD_CAFE, 1'b1, cyc, d, e);
        check("drop.latency", cyc, LATENCY);
        check("drop.err", {31'd0, e}, 32'd0);
        run_txn("drop_rd", 1'b0, 32'h0000_0024, 4'b1111, 32'h0, 1'b0, cyc, d, e);
        check("drop_rd.data", d, 32'h0BAD_CAFE);

        // ---------------- reset during WAIT of a write ----------------
        ram_ce_i   = 1'b1;
        ram_we_i   = 1'b1;
        ram_addr_i = 32'h0000_0020;
        ram_sel_i  = 4'b1111;
        ram_data_i = 32'h1234_5678;
        @(negedge clk);
        check("rstw.in_wait", {30'd0, dbg_state}, 32'd1);
        ram_ce_i = 1'b0;
        rst = 1'b0;
        #1;
        check("rstw.ack",   {31'd0, ram_ack_o}, 32'd0);
        check("rstw.err",   {31'd0, ram_err_o}, 32'd0);
        check("rstw.data",  ram_data_o, 32'd0);
        check("rstw.state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        n_acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ram_ack_o) n_acks++;
        end
        check("rstw.no_ack", n_acks, 32'd0);
        run_txn("rstw_rd", 1'b0, 32'h0000_0020, 4'b1111, 32'h0, 1'b0, cyc, d, e);
        check("rstw_rd.latency", cyc, LATENCY);
        check("rstw_rd.data", d, 32'hA5A5_A5A5);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
